// File: rtl/descriptor_memory_dp.sv
// True-dual-port descriptor RAM with optional clear pass after reset, a 1- or 2-cycle read
// pipeline with readdatavalid, and s1-wins arbitration for same-address writes.
module descriptor_memory_dp #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
    parameter int                    RDW_NEW_DATA   = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      s1_chipselect,
    input  logic [ADDR_WIDTH-1:0]     s1_address,
    input  logic                      s1_read,
    input  logic                      s1_write,
    input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
    input  logic [DATA_WIDTH-1:0]     s1_writedata,
    output logic [DATA_WIDTH-1:0]     s1_readdata,
    output logic                      s1_readdatavalid,
    output logic                      s1_waitrequest,
    input  logic                      s2_chipselect,
    input  logic [ADDR_WIDTH-1:0]     s2_address,
    input  logic                      s2_read,
    input  logic                      s2_write,
    input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
    input  logic [DATA_WIDTH-1:0]     s2_writedata,
    output logic [DATA_WIDTH-1:0]     s2_readdata,
    output logic                      s2_readdatavalid,
    output logic                      s2_waitrequest,
    output logic                      init_done,
    output logic [1:0]                o_dbg_state
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_SKIP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_SKIP;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_init_cnt;
    logic                    r_init_done;
    logic                    w_run;
    logic                    w_init_we;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_s1_wr;
    logic                    w_s1_rd;
    logic                    w_s2_wr_req;
    logic                    w_s2_wr;
    logic                    w_s2_rd;
    logic                    w_collide;
    logic [DATA_WIDTH-1:0]   w_s1_old;
    logic [DATA_WIDTH-1:0]   w_s2_old;
    logic [DATA_WIDTH-1:0]   w_s1_rd_word;
    logic [DATA_WIDTH-1:0]   w_s2_rd_word;
    logic                    w_s1_stg_vld;
    logic                    w_s2_stg_vld;
    logic [DATA_WIDTH-1:0]   w_s1_stg_data;
    logic [DATA_WIDTH-1:0]   w_s2_stg_data;

    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0]   old_w,
        input logic [DATA_WIDTH-1:0]   new_w,
        input logic [DATA_WIDTH/8-1:0] be
    );
        f_merge = old_w;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (be[b]) begin
                f_merge[8*b +: 8] = new_w[8*b +: 8];
            end
        end
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RST_STATE;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= (w_state_nxt == ST_RUN);
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        w_init_we   = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_we = 1'b1;
                if (r_init_cnt == '1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SKIP: w_state_nxt = ST_RUN;
            ST_RUN:  w_run = 1'b1;
            default: w_state_nxt = RST_STATE;
        endcase
    end

    assign init_done   = r_init_done;
    assign o_dbg_state = r_state;

    // A write wins over a read issued on the same port in the same cycle.
    assign w_s1_wr     = w_run & s1_chipselect & s1_write;
    assign w_s1_rd     = w_run & s1_chipselect & s1_read & ~s1_write;
    assign w_s2_wr_req = s2_chipselect & s2_write;
    assign w_collide   = w_s1_wr & w_s2_wr_req & (s1_address == s2_address);
    assign w_s2_wr     = w_run & w_s2_wr_req & ~w_collide;
    assign w_s2_rd     = w_run & s2_chipselect & s2_read & ~s2_write;

    assign s1_waitrequest = ~w_run;
    assign s2_waitrequest = ~w_run | w_collide;

    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[r_init_cnt] <= INIT_VALUE;
        end else begin
            if (w_s1_wr) begin
                r_mem[s1_address] <= f_merge(r_mem[s1_address], s1_writedata, s1_byteenable);
            end
            if (w_s2_wr) begin
                r_mem[s2_address] <= f_merge(r_mem[s2_address], s2_writedata, s2_byteenable);
            end
        end
    end

    assign w_s1_old = r_mem[s1_address];
    assign w_s2_old = r_mem[s2_address];

    // Cross-port read-during-write: optionally forward the bytes being written this cycle.
    assign w_s1_rd_word = ((RDW_NEW_DATA != 0) && w_s2_wr && (s2_address == s1_address))
                        ? f_merge(w_s1_old, s2_writedata, s2_byteenable) : w_s1_old;
    assign w_s2_rd_word = ((RDW_NEW_DATA != 0) && w_s1_wr && (s1_address == s2_address))
                        ? f_merge(w_s2_old, s1_writedata, s1_byteenable) : w_s2_old;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_s1_vld;
            logic                  r_s2_vld;
            logic [DATA_WIDTH-1:0] r_s1_data;
            logic [DATA_WIDTH-1:0] r_s2_data;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_s1_vld  <= 1'b0;
                    r_s2_vld  <= 1'b0;
                    r_s1_data <= '0;
                    r_s2_data <= '0;
                end else begin
                    r_s1_vld <= w_s1_rd;
                    r_s2_vld <= w_s2_rd;
                    if (w_s1_rd) begin
                        r_s1_data <= w_s1_rd_word;
                    end
                    if (w_s2_rd) begin
                        r_s2_data <= w_s2_rd_word;
                    end
                end
            end

            assign w_s1_stg_vld  = r_s1_vld;
            assign w_s2_stg_vld  = r_s2_vld;
            assign w_s1_stg_data = r_s1_data;
            assign w_s2_stg_data = r_s2_data;
        end else begin : g_lat1
            assign w_s1_stg_vld  = w_s1_rd;
            assign w_s2_stg_vld  = w_s2_rd;
            assign w_s1_stg_data = w_s1_rd_word;
            assign w_s2_stg_data = w_s2_rd_word;
        end
    endgenerate

    // Output stage: readdata only moves on a valid beat and holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_readdata      <= '0;
            s2_readdata      <= '0;
            s1_readdatavalid <= 1'b0;
            s2_readdatavalid <= 1'b0;
        end else begin
            s1_readdatavalid <= w_s1_stg_vld;
            s2_readdatavalid <= w_s2_stg_vld;
            if (w_s1_stg_vld) begin
                s1_readdata <= w_s1_stg_data;
            end
            if (w_s2_stg_vld) begin
                s2_readdata <= w_s2_stg_data;
            end
        end
    end

endmodule

// File: tb/tb_descriptor_memory_dp.sv
// Bench for descriptor_memory_dp: two instances (latency 1 / old-data RDW, latency 2 /
// new-data RDW) share one stimulus stream and are compared against a word-array model.
module tb_descriptor_memory_dp;

  localparam int DEPTH = 1024;

  typedef struct packed {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    int          due;
    int          k;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  req_t p1, p2, n1, n2;

  logic [31:0] rd1 [2];
  logic [31:0] rd2 [2];
  logic        rv1 [2];
  logic        rv2 [2];
  logic        wq1 [2];
  logic        wq2 [2];
  logic        done [2];
  logic [1:0]  dbg [2];

  logic [31:0] mem [DEPTH];
  exp_t        exp_q [$];
  logic [31:0] last_d [4];
  bit          in_init;
  int          init_cnt;
  int          cyc;
  bit          s2_stalled;
  int          n_vec;
  int          n_err;

  always #5 clk = ~clk;

  descriptor_memory_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(1), .CLEAR_ON_RESET(1),
    .INIT_VALUE(32'h0), .RDW_NEW_DATA(0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n),
    .s1_chipselect(p1.cs), .s1_address(p1.addr), .s1_read(p1.rd), .s1_write(p1.wr),
    .s1_byteenable(p1.be), .s1_writedata(p1.wd), .s1_readdata(rd1[0]),
    .s1_readdatavalid(rv1[0]), .s1_waitrequest(wq1[0]),
    .s2_chipselect(p2.cs), .s2_address(p2.addr), .s2_read(p2.rd), .s2_write(p2.wr),
    .s2_byteenable(p2.be), .s2_writedata(p2.wd), .s2_readdata(rd2[0]),
    .s2_readdatavalid(rv2[0]), .s2_waitrequest(wq2[0]),
    .init_done(done[0]), .o_dbg_state(dbg[0])
  );

  descriptor_memory_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(2), .CLEAR_ON_RESET(1),
    .INIT_VALUE(32'h0), .RDW_NEW_DATA(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n),
    .s1_chipselect(p1.cs), .s1_address(p1.addr), .s1_read(p1.rd), .s1_write(p1.wr),
    .s1_byteenable(p1.be), .s1_writedata(p1.wd), .s1_readdata(rd1[1]),
    .s1_readdatavalid(rv1[1]), .s1_waitrequest(wq1[1]),
    .s2_chipselect(p2.cs), .s2_address(p2.addr), .s2_read(p2.rd), .s2_write(p2.wr),
    .s2_byteenable(p2.be), .s2_writedata(p2.wd), .s2_readdata(rd2[1]),
    .s2_readdatavalid(rv2[1]), .s2_waitrequest(wq2[1]),
    .init_done(done[1]), .o_dbg_state(dbg[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %08h expected %08h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic req_t idle_req();
    req_t r;
    r = '0;
    return r;
  endfunction

  function automatic req_t mk_req(input logic rd, input logic wr, input logic [9:0] addr,
                                  input logic [3:0] be, input logic [31:0] wd);
    req_t r;
    r.cs = 1'b1; r.rd = rd; r.wr = wr; r.addr = addr; r.be = be; r.wd = wd;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.cs   = ($urandom_range(0, 3) != 0);
    r.rd   = 1'($urandom_range(0, 1));
    r.wr   = 1'($urandom_range(0, 1));
    r.addr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, DEPTH - 1))
                                         : 10'($urandom_range(0, 15));
    r.be   = 4'($urandom_range(0, 15));
    r.wd   = $urandom;
    return r;
  endfunction

  // k = instance*2 + port
  function automatic logic get_v(input int k);
    case (k)
      0: return rv1[0];
      1: return rv2[0];
      2: return rv1[1];
      default: return rv2[1];
    endcase
  endfunction

  function automatic logic [31:0] get_d(input int k);
    case (k)
      0: return rd1[0];
      1: return rd2[0];
      2: return rd1[1];
      default: return rd2[1];
    endcase
  endfunction

  task automatic check_outputs();
    bit          ev [4];
    logic [31:0] ed [4];
    for (int k = 0; k < 4; k++) begin
      ev[k] = 1'b0;
      ed[k] = '0;
    end
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j].due == cyc) begin
        ev[exp_q[j].k] = 1'b1;
        ed[exp_q[j].k] = exp_q[j].data;
        exp_q.delete(j);
      end
    end
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rvalid%0d", k), {31'b0, get_v(k)}, {31'b0, ev[k]});
      if (ev[k]) begin
        check_eq($sformatf("rdata%0d", k), get_d(k), ed[k]);
        last_d[k] = ed[k];
      end else begin
        check_eq($sformatf("rhold%0d", k), get_d(k), last_d[k]);
      end
    end
  endtask

  task automatic step();
    logic a1w, a1r, a2w, a2r, col;
    logic [31:0] old_w, v;
    exp_t e;
    @(negedge clk);
    p1 = n1;
    p2 = n2;
    #1;
    check_outputs();
    a1w = 1'b0; a1r = 1'b0; a2w = 1'b0; a2r = 1'b0; col = 1'b0;
    if (!in_init) begin
      a1w = p1.cs & p1.wr;
      a1r = p1.cs & p1.rd & ~p1.wr;
      col = a1w & p2.cs & p2.wr & (p1.addr == p2.addr);
      a2w = p2.cs & p2.wr & ~col;
      a2r = p2.cs & p2.rd & ~p2.wr;
    end
    for (int i = 0; i < 2; i++) begin
      check_eq("s1_waitrequest", {31'b0, wq1[i]}, {31'b0, in_init});
      check_eq("s2_waitrequest", {31'b0, wq2[i]}, {31'b0, in_init | col});
      check_eq("init_done", {31'b0, done[i]}, {31'b0, !in_init});
    end
    if (in_init) begin
      mem[init_cnt] = 32'h0;
      init_cnt++;
      if (init_cnt == DEPTH) in_init = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (a1r) begin
          old_w = mem[p1.addr];
          v = (i == 1 && a2w && p2.addr == p1.addr) ? merge_be(old_w, p2.wd, p2.be) : old_w;
          e.due = cyc + i + 1; e.k = i * 2; e.data = v;
          exp_q.push_back(e);
        end
        if (a2r) begin
          old_w = mem[p2.addr];
          v = (i == 1 && a1w && p1.addr == p2.addr) ? merge_be(old_w, p1.wd, p1.be) : old_w;
          e.due = cyc + i + 1; e.k = i * 2 + 1; e.data = v;
          exp_q.push_back(e);
        end
      end
      if (a1w) mem[p1.addr] = merge_be(mem[p1.addr], p1.wd, p1.be);
      if (a2w) mem[p2.addr] = merge_be(mem[p2.addr], p2.wd, p2.be);
    end
    s2_stalled = col;
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    n1 = idle_req();
    n2 = idle_req();
    repeat (n) step();
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    p1 = idle_req(); p2 = idle_req();
    n1 = idle_req(); n2 = idle_req();
    #1;
    check_outputs();
    cyc++;
    reset_n = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) last_d[k] = '0;
    in_init = 1'b1;
    init_cnt = 0;
    s2_stalled = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_rdata1", rd1[i], 32'h0);
      check_eq("rst_rdata2", rd2[i], 32'h0);
      check_eq("rst_rvalid1", {31'b0, rv1[i]}, 32'h0);
      check_eq("rst_rvalid2", {31'b0, rv2[i]}, 32'h0);
      check_eq("rst_wait1", {31'b0, wq1[i]}, 32'h1);
      check_eq("rst_wait2", {31'b0, wq2[i]}, 32'h1);
      check_eq("rst_init_done", {31'b0, done[i]}, 32'h0);
    end
    repeat (hold) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_hold_rvalid1", {31'b0, rv1[i]}, 32'h0);
      check_eq("rst_hold_rvalid2", {31'b0, rv2[i]}, 32'h0);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    for (int k = 0; k < 4; k++) last_d[k] = '0;
    p1 = idle_req(); p2 = idle_req();
    n1 = idle_req(); n2 = idle_req();

    do_reset(3);
    // Requests presented during the clear pass stay pending and land on the first run cycle.
    n1 = mk_req(1'b0, 1'b1, 10'h005, 4'hF, 32'h12345678);
    n2 = mk_req(1'b1, 1'b0, 10'h005, 4'h0, 32'h0);
    repeat (DEPTH + 1) step();
    idle_steps(3);

    n1 = mk_req(1'b1, 1'b0, 10'h3FF, 4'h0, 32'h0);
    step();
    idle_steps(3);

    n1 = mk_req(1'b0, 1'b1, 10'h010, 4'hF, 32'h11223344);
    step();
    n1 = mk_req(1'b0, 1'b1, 10'h010, 4'b0101, 32'hDEADBEEF);
    step();
    n1 = idle_req();
    n2 = mk_req(1'b1, 1'b0, 10'h010, 4'h0, 32'h0);
    step();
    idle_steps(3);

    n1 = mk_req(1'b0, 1'b1, 10'h020, 4'hF, 32'hAAAAAAAA);
    n2 = mk_req(1'b0, 1'b1, 10'h020, 4'hF, 32'h55555555);
    step();
    n1 = idle_req();
    step();
    n2 = idle_req();
    n1 = mk_req(1'b1, 1'b0, 10'h020, 4'h0, 32'h0);
    step();
    idle_steps(3);

    n1 = mk_req(1'b0, 1'b1, 10'h030, 4'hF, 32'hCAFEF00D);
    n2 = mk_req(1'b1, 1'b0, 10'h030, 4'h0, 32'h0);
    step();
    idle_steps(3);

    for (int a = 0; a < 8; a++) begin
      n1 = mk_req(1'b0, 1'b1, 10'(a), 4'hF, $urandom);
      step();
    end
    n1 = idle_req();
    for (int a = 0; a < 8; a++) begin
      n2 = mk_req(1'b1, 1'b0, 10'(a), 4'h0, 32'h0);
      step();
    end
    idle_steps(3);

    n2 = mk_req(1'b1, 1'b1, 10'h040, 4'hF, 32'h0BADF00D);
    step();
    n2 = mk_req(1'b1, 1'b0, 10'h040, 4'h0, 32'h0);
    step();
    idle_steps(3);

    for (int n = 0; n < 1500; n++) begin
      n1 = rand_req();
      if (!s2_stalled) n2 = rand_req();
      step();
    end
    idle_steps(3);

    n2 = mk_req(1'b1, 1'b0, 10'h010, 4'h0, 32'h0);
    step();
    do_reset(2);
    idle_steps(500);
    do_reset(2);
    idle_steps(DEPTH);
    for (int n = 0; n < 300; n++) begin
      n1 = rand_req();
      if (!s2_stalled) n2 = rand_req();
      step();
    end
    idle_steps(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
